// File: rtl/line_fill_arbiter_if.sv
// Requester and AXI4 read-channel signals of the line-fill arbiter, bundled.
// slave: arbiter side; master: requesters plus the L2/memory read port.
interface line_fill_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [1:0]              req_valid;
    logic [1:0]              req_ready;
    logic [2*ADDR_WIDTH-1:0] req_addr;

    logic [1:0]              fill_valid;
    logic [DATA_WIDTH-1:0]   fill_data;
    logic                    fill_last;
    logic                    fill_err;
    logic                    proto_err;

    logic [ADDR_WIDTH-1:0]   m_araddr;
    logic [7:0]              m_arlen;
    logic [2:0]              m_arsize;
    logic [1:0]              m_arburst;
    logic                    m_arvalid;
    logic                    m_arready;

    logic [DATA_WIDTH-1:0]   m_rdata;
    logic [1:0]              m_rresp;
    logic                    m_rlast;
    logic                    m_rvalid;
    logic                    m_rready;

    modport slave (
        input  req_valid, req_addr,
        output req_ready,
        output fill_valid, fill_data, fill_last, fill_err, proto_err,
        output m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        input  m_arready,
        input  m_rdata, m_rresp, m_rlast, m_rvalid,
        output m_rready
    );

    modport master (
        output req_valid, req_addr,
        input  req_ready,
        input  fill_valid, fill_data, fill_last, fill_err, proto_err,
        input  m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        output m_arready,
        output m_rdata, m_rresp, m_rlast, m_rvalid,
        input  m_rready
    );
endinterface

// File: rtl/line_fill_arbiter.sv
// Round-robin share of one AXI4 read port between I-cache (0) and D-cache (1) line fills.
// Latency: request accepted in IDLE, AR issued next cycle, R beats passed through combinationally.
// Backpressure: AR held until m_arready; R is never backpressured; one burst outstanding.
module line_fill_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_WORDS = 8
) (
    input logic                clk,
    input logic                rst_n,
    line_fill_arbiter_if.slave bus
);

    localparam int OFFSET_BITS = $clog2(LINE_WORDS * DATA_WIDTH / 8);
    localparam int CNT_W       = $clog2(LINE_WORDS);

    localparam logic [CNT_W-1:0]      LAST_BEAT   = CNT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK   = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;
    localparam logic [2:0]            SIZE_4_BYTE = 3'b010;
    localparam logic [1:0]            BURST_INCR  = 2'b01;
    localparam logic [1:0]            RESP_OKAY   = 2'b00;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    logic [1:0]            state_q,      state_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] araddr_q,     araddr_d;
    logic                  arvalid_q,    arvalid_d;
    logic [CNT_W-1:0]      cnt_q,        cnt_d;
    logic                  err_acc_q,    err_acc_d;
    logic                  proto_err_q,  proto_err_d;

    logic                  any_req;
    logic                  win;
    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  in_data;
    logic                  beat_err;

    // The requester that did not win last time has priority; otherwise whoever is asking.
    always_comb begin
        any_req = |bus.req_valid;
        win     = 1'b0;
        if (bus.req_valid[~last_grant_q]) begin
            win = ~last_grant_q;
        end else begin
            win = ~bus.req_valid[0];
        end
        win_addr = win ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                       : bus.req_addr[ADDR_WIDTH-1:0];
    end

    assign in_data  = (state_q == ST_DATA);
    assign beat_err = (bus.m_rresp != RESP_OKAY);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        araddr_d     = araddr_q;
        arvalid_d    = arvalid_q;
        cnt_d        = cnt_q;
        err_acc_d    = err_acc_q;
        proto_err_d  = proto_err_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    araddr_d     = win_addr & LINE_MASK;
                    last_grant_d = win;
                    arvalid_d    = 1'b1;
                    state_d      = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (bus.m_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bus.m_rvalid) begin
                    if (bus.m_rlast) begin
                        if (cnt_q != LAST_BEAT) begin
                            proto_err_d = 1'b1;
                        end
                        cnt_d     = '0;
                        err_acc_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        // Overlong burst: flag it, hold the count, keep draining until rlast.
                        if (cnt_q == LAST_BEAT) begin
                            proto_err_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        err_acc_d = err_acc_q | beat_err;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            cnt_q        <= '0;
            err_acc_q    <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            cnt_q        <= cnt_d;
            err_acc_q    <= err_acc_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE && any_req) ? (win ? 2'b10 : 2'b01) : 2'b00;

    assign bus.m_araddr   = araddr_q;
    assign bus.m_arvalid  = arvalid_q;
    assign bus.m_arlen    = 8'(LINE_WORDS - 1);
    assign bus.m_arsize   = SIZE_4_BYTE;
    assign bus.m_arburst  = BURST_INCR;
    assign bus.m_rready   = in_data;

    assign bus.fill_valid = (in_data && bus.m_rvalid) ? (last_grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign bus.fill_data  = in_data ? bus.m_rdata : '0;
    assign bus.fill_last  = in_data & bus.m_rvalid & bus.m_rlast;
    assign bus.fill_err   = bus.fill_last & (err_acc_q | beat_err);
    assign bus.proto_err  = proto_err_q;

endmodule

// File: tb/tb_line_fill_arbiter.sv
// Bench for line_fill_arbiter: directed vector table, random fills against a grant/address model,
// and hand sequences for protocol errors and mid-burst reset.
module tb_line_fill_arbiter;

    localparam int AW         = 32;
    localparam int DW         = 32;
    localparam int LW         = 8;
    localparam int LINE_BYTES = LW * DW / 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    line_fill_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    line_fill_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk     = 0;
    int n_pass    = 0;
    int model_lg  = 1;
    bit exp_proto = 1'b0;

    typedef struct {
        logic [1:0]  rv;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  exp_rdy;
        logic [31:0] exp_addr;
        int          ar_dly;
        int          err_beat;
        int          gap_pct;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Round robin by rule: the requester not served last time wins if it is asking.
    function automatic int pick(input logic [1:0] rv);
        int o;
        o = 1 - model_lg;
        if (rv[o]) return o;
        return rv[0] ? 0 : 1;
    endfunction

    task automatic request(input logic [1:0] rv, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [1:0] exp_rdy, input logic [31:0] exp_addr, input string tag);
        bus.req_valid = rv;
        bus.req_addr  = {a1, a0};
        #2 chk({tag, ".req_ready"}, 64'(bus.req_ready), 64'(exp_rdy));
        tick();
        if (exp_rdy != 2'b00) begin
            bus.req_valid = 2'b11;
            bus.req_addr  = ~{a1, a0};
            model_lg      = exp_rdy[1] ? 1 : 0;
            #2;
            chk({tag, ".arvalid"}, 64'(bus.m_arvalid), 64'(1));
            chk({tag, ".araddr"}, 64'(bus.m_araddr), 64'(exp_addr));
        end else begin
            bus.req_valid = 2'b00;
            #2 chk({tag, ".arvalid_idle"}, 64'(bus.m_arvalid), 64'(0));
        end
    endtask

    task automatic ar_accept(input int dly, input logic [31:0] exp_addr);
        bus.m_rvalid = 1'b1;
        bus.m_rlast  = 1'b1;
        for (int k = 0; k < dly; k++) begin
            bus.m_arready = 1'b0;
            #2;
            chk("ar_wait.arvalid", 64'(bus.m_arvalid), 64'(1));
            chk("ar_wait.araddr", 64'(bus.m_araddr), 64'(exp_addr));
            chk("ar_wait.fill_valid", 64'(bus.fill_valid), 64'(0));
            chk("ar_wait.req_ready", 64'(bus.req_ready), 64'(0));
            tick();
        end
        bus.m_arready = 1'b1;
        #2 chk("ar_hs.arvalid", 64'(bus.m_arvalid), 64'(1));
        tick();
        bus.m_arready = 1'b0;
        bus.m_rvalid  = 1'b0;
        bus.m_rlast   = 1'b0;
        #2;
        chk("ar_done.arvalid", 64'(bus.m_arvalid), 64'(0));
        chk("ar_done.rready", 64'(bus.m_rready), 64'(1));
    endtask

    task automatic beats(input int g, input int last_at, input int err_beat, input int gap_pct);
        bit          acc_err;
        logic [31:0] d;
        acc_err = 1'b0;
        for (int i = 0; i <= last_at; i++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 99) >= gap_pct) break;
                bus.m_rvalid = 1'b0;
                bus.m_rlast  = 1'($urandom);
                bus.m_rresp  = 2'b10;
                #2;
                chk("gap.fill_valid", 64'(bus.fill_valid), 64'(0));
                chk("gap.fill_last", 64'(bus.fill_last), 64'(0));
                tick();
            end
            d = $urandom;
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = d;
            bus.m_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            bus.m_rlast  = (i == last_at);
            if (i == err_beat) acc_err = 1'b1;
            #2;
            chk("beat.fill_valid", 64'(bus.fill_valid), 64'(g == 1 ? 2'b10 : 2'b01));
            chk("beat.fill_data", 64'(bus.fill_data), 64'(d));
            chk("beat.fill_last", 64'(bus.fill_last), 64'(i == last_at));
            chk("beat.fill_err", 64'(bus.fill_err), 64'((i == last_at) && acc_err));
            chk("beat.req_ready", 64'(bus.req_ready), 64'(0));
            tick();
        end
        bus.m_rvalid  = 1'b0;
        bus.m_rlast   = 1'b0;
        bus.m_rresp   = 2'b00;
        bus.req_valid = 2'b00;
        if (last_at != LW - 1) exp_proto = 1'b1;
        #2;
        chk("end.rready", 64'(bus.m_rready), 64'(0));
        chk("end.fill_valid", 64'(bus.fill_valid), 64'(0));
        chk("end.proto_err", 64'(bus.proto_err), 64'(exp_proto));
    endtask

    task automatic auto_txn(input logic [1:0] rv, input logic [31:0] a0, input logic [31:0] a1,
                            input int ar, input int err, input int gap, input int last_at);
        int          g;
        logic [1:0]  er;
        logic [31:0] ea;
        g  = 0;
        er = 2'b00;
        ea = '0;
        if (rv != 2'b00) begin
            g  = pick(rv);
            er = (g == 1) ? 2'b10 : 2'b01;
            ea = 32'((((g == 1) ? a1 : a0) / LINE_BYTES) * LINE_BYTES);
        end
        request(rv, a0, a1, er, ea, "txn");
        if (rv != 2'b00) begin
            ar_accept(ar, ea);
            beats(g, last_at, err, gap);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".req_ready"}, 64'(bus.req_ready), 64'(0));
        chk({tag, ".fill_valid"}, 64'(bus.fill_valid), 64'(0));
        chk({tag, ".fill_data"}, 64'(bus.fill_data), 64'(0));
        chk({tag, ".fill_last"}, 64'(bus.fill_last), 64'(0));
        chk({tag, ".fill_err"}, 64'(bus.fill_err), 64'(0));
        chk({tag, ".proto_err"}, 64'(bus.proto_err), 64'(0));
        chk({tag, ".arvalid"}, 64'(bus.m_arvalid), 64'(0));
        chk({tag, ".araddr"}, 64'(bus.m_araddr), 64'(0));
        chk({tag, ".rready"}, 64'(bus.m_rready), 64'(0));
        chk({tag, ".arlen"}, 64'(bus.m_arlen), 64'(7));
        chk({tag, ".arsize"}, 64'(bus.m_arsize), 64'(2));
        chk({tag, ".arburst"}, 64'(bus.m_arburst), 64'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b00 | 2'b01, 32'h0000_1234, 32'hDEAD_BEEF, 2'b01, 32'h0000_1220, 0, -1, 0};
        vecs[1] = '{2'b11, 32'h1000_0040, 32'h2000_005C, 2'b10, 32'h2000_0040, 0, -1, 0};
        vecs[2] = '{2'b11, 32'h1000_0040, 32'h2000_005C, 2'b01, 32'h1000_0040, 0, -1, 0};
        vecs[3] = '{2'b11, 32'h1000_0040, 32'h2000_005C, 2'b10, 32'h2000_0040, 0, -1, 0};
        vecs[4] = '{2'b00, 32'h1111_1111, 32'h2222_2222, 2'b00, 32'h0000_0000, 0, -1, 0};
        vecs[5] = '{2'b10, 32'h0000_0000, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFE0, 5, -1, 0};
        vecs[6] = '{2'b10, 32'h0000_0000, 32'h0000_003F, 2'b10, 32'h0000_0020, 0, 3, 40};
        vecs[7] = '{2'b01, 32'h0000_001F, 32'h0000_0000, 2'b01, 32'h0000_0000, 0, -1, 30};
        vecs[8] = '{2'b11, 32'hAAAA_AAAA, 32'h5555_5555, 2'b10, 32'h5555_5540, 1, -1, 0};
        vecs[9] = '{2'b11, 32'hAAAA_AAAA, 32'h5555_5555, 2'b01, 32'hAAAA_AAA0, 2, 7, 20};

        bus.req_valid = 2'b00;
        bus.req_addr  = '0;
        bus.m_arready = 1'b0;
        bus.m_rdata   = '0;
        bus.m_rresp   = 2'b00;
        bus.m_rlast   = 1'b0;
        bus.m_rvalid  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            request(vecs[i].rv, vecs[i].a0, vecs[i].a1, vecs[i].exp_rdy, vecs[i].exp_addr, "vec");
            if (vecs[i].exp_rdy != 2'b00) begin
                ar_accept(vecs[i].ar_dly, vecs[i].exp_addr);
                beats(vecs[i].exp_rdy[1] ? 1 : 0, LW - 1, vecs[i].err_beat, vecs[i].gap_pct);
            end
        end

        for (int i = 0; i < 40; i++) begin
            auto_txn(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 3),
                     $urandom_range(0, 15), $urandom_range(0, 50), LW - 1);
        end

        // Overlong burst: count reaches the end without rlast, beats keep flowing until rlast.
        auto_txn(2'b10, 32'h0000_5000, 32'h0000_6004, 0, -1, 0, 9);
        bus.req_valid = 2'b00;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        model_lg  = 1;
        exp_proto = 1'b0;
        #2 chk("proto_cleared", 64'(bus.proto_err), 64'(0));

        // Short burst: rlast on the fifth beat, then a clean fill keeps the sticky flag.
        auto_txn(2'b01, 32'h4000_0010, 32'h0, 1, -1, 0, 4);
        auto_txn(2'b01, 32'h4000_0110, 32'h0, 0, -1, 0, LW - 1);
        auto_txn(2'b11, 32'h4000_0210, 32'h4000_0310, 0, 2, 0, LW - 1);

        // Reset during the data phase after two beats.
        request(2'b01, 32'h0000_0300, 32'h0000_0700, 2'b01, 32'h0000_0300, "rst_req");
        ar_accept(0, 32'h0000_0300);
        for (int i = 0; i < 2; i++) begin
            bus.m_rvalid = 1'b1;
            bus.m_rdata  = 32'(i);
            #2 chk("pre_rst.fill_valid", 64'(bus.fill_valid), 64'(2'b01));
            tick();
        end
        bus.m_rvalid  = 1'b1;
        bus.m_rlast   = 1'b0;
        bus.req_valid = 2'b00;
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        bus.m_rvalid = 1'b0;
        tick();
        rst_n     = 1'b1;
        model_lg  = 1;
        exp_proto = 1'b0;
        request(2'b11, 32'h0000_0800, 32'h0000_0900, 2'b01, 32'h0000_0800, "post_rst");
        ar_accept(0, 32'h0000_0800);
        beats(0, LW - 1, -1, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
